// File: rtl/lcd_win_ctrl.sv
// LCD window controller: holds an IMG x IMG image, keeps a movable and
// mirrorable WIN x WIN window into it, and streams that window out in raster
// order after every accepted command.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for cmd_valid; busy=0
// S_LOAD   | writing datain into the image buffer, row-major
// S_UPDATE | one cycle: apply move / mirror / re-centre for the command
// S_OUTPUT | WIN*WIN pixel cycles, then one closing cycle back to idle
module lcd_win_ctrl #(
    parameter int DW  = 8,
    parameter int IMG = 6,
    parameter int WIN = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int CW   = $clog2(IMG);
    localparam int NPIX = IMG * IMG;
    localparam int LW   = $clog2(NPIX);
    localparam int RW   = $clog2(WIN + 1);

    localparam logic [CW-1:0] OMAX  = CW'(IMG - WIN);
    localparam logic [CW-1:0] OCTR  = CW'((IMG - WIN) / 2);
    localparam logic [LW-1:0] LAST  = LW'(NPIX - 1);
    localparam logic [LW-1:0] IMG_L = LW'(IMG);
    localparam logic [RW-1:0] WLAST = RW'(WIN - 1);
    localparam logic [RW-1:0] WEND  = RW'(WIN);

    localparam logic [2:0] C_REFRESH = 3'd0;
    localparam logic [2:0] C_LOAD    = 3'd1;
    localparam logic [2:0] C_RIGHT   = 3'd2;
    localparam logic [2:0] C_LEFT    = 3'd3;
    localparam logic [2:0] C_UP      = 3'd4;
    localparam logic [2:0] C_DOWN    = 3'd5;
    localparam logic [2:0] C_MIRX    = 3'd6;
    localparam logic [2:0] C_MIRY    = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_OUTPUT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          mx_q, mx_d, my_q, my_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [RW-1:0] r_q, r_d, c_q, c_d;
    logic [DW-1:0] buf_q [NPIX];
    logic [DW-1:0] buf_d [NPIX];
    logic [DW-1:0] dout_q, dout_d;
    logic          ov_q, ov_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] row_off, col_off, row_idx, col_idx;
    logic [LW-1:0] pix_addr;

    // Source pixel address for window position (r_q, c_q), mirrors applied
    always_comb begin
        row_off  = my_q ? CW'(WLAST - r_q) : CW'(r_q);
        col_off  = mx_q ? CW'(WLAST - c_q) : CW'(c_q);
        row_idx  = oy_q + row_off;
        col_idx  = ox_q + col_off;
        pix_addr = LW'(row_idx) * IMG_L + LW'(col_idx);
    end

    // Next-state and next-output computation for the command sequencer
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        mx_d    = mx_q;
        my_d    = my_q;
        lcnt_d  = lcnt_q;
        r_d     = r_q;
        c_d     = c_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        ov_d    = ov_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d  = cmd;
                    busy_d = 1'b1;
                    lcnt_d = '0;
                    state_d = (cmd == C_LOAD) ? S_LOAD : S_UPDATE;
                end
            end
            S_LOAD: begin
                buf_d[lcnt_q] = datain;
                if (lcnt_q == LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            S_UPDATE: begin
                case (cmd_q)
                    C_LOAD: begin
                        ox_d = OCTR;
                        oy_d = OCTR;
                        mx_d = 1'b0;
                        my_d = 1'b0;
                    end
                    C_RIGHT: if (ox_q < OMAX)  ox_d = ox_q + CW'(1);
                    C_LEFT:  if (ox_q != '0)   ox_d = ox_q - CW'(1);
                    C_DOWN:  if (oy_q < OMAX)  oy_d = oy_q + CW'(1);
                    C_UP:    if (oy_q != '0)   oy_d = oy_q - CW'(1);
                    C_MIRX:  mx_d = ~mx_q;
                    C_MIRY:  my_d = ~my_q;
                    C_REFRESH: ;
                    default: ;
                endcase
                r_d     = '0;
                c_d     = '0;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (r_q != WEND) begin
                    dout_d = buf_q[pix_addr];
                    ov_d   = 1'b1;
                    if (c_q == WLAST) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                    end else begin
                        c_d = c_q + RW'(1);
                    end
                end else begin
                    // closing cycle after the last pixel
                    dout_d  = '0;
                    ov_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, buffer and registered outputs; reset clears the image too
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            ox_q    <= OCTR;
            oy_q    <= OCTR;
            mx_q    <= 1'b0;
            my_q    <= 1'b0;
            lcnt_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            for (int i = 0; i < NPIX; i++) buf_q[i] <= '0;
            dout_q  <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            lcnt_q  <= lcnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    assign dataout      = dout_q;
    assign output_valid = ov_q;
    assign busy         = busy_q;

endmodule
